// File: rtl/rr_encoder_32_5.sv
// Round-robin 32-to-5 request encoder: captures a multi-hot request vector and
// serializes the set-bit indices over a valid/ready handshake, starting from a persistent pointer.
module rr_encoder_32_5 (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] ReqIn,
  input  logic        Load,
  input  logic        Ready,
  output logic [4:0]  Addr,
  output logic        Valid,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pending_r;
  logic [4:0]  ptr_r;
  logic [31:0] rem_s;
  logic [4:0]  addr_inc_s;

  // First set bit of p scanning upward from s, wrapping modulo 32.
  function automatic logic [4:0] search(input logic [31:0] p, input logic [4:0] s);
    logic [4:0] idx;
    logic       found;
    search = 5'd0;
    found  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      idx = s + 5'(i);
      if (!found && p[idx]) begin
        search = idx;
        found  = 1'b1;
      end
    end
  endfunction

  // Requests left after the offered address is accepted, and the wrapped successor address.
  always_comb begin
    rem_s      = pending_r & ~(32'd1 << Addr);
    addr_inc_s = Addr + 5'd1;
  end

  // Batch FSM; all outputs are registered here.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r   <= IDLE;
      pending_r <= 32'd0;
      ptr_r     <= 5'd0;
      Addr      <= 5'd0;
      Valid     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          Valid <= 1'b0;
          Done  <= 1'b0;
          if (Load) begin
            pending_r <= ReqIn;
            Busy      <= 1'b1;
            state_r   <= FIRST;
          end else begin
            Busy <= 1'b0;
          end
        end
        FIRST: begin
          if (pending_r == 32'd0) begin
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state_r <= DONE;
          end else begin
            Addr    <= search(pending_r, ptr_r);
            Valid   <= 1'b1;
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          if (Ready) begin
            pending_r <= rem_s;
            ptr_r     <= addr_inc_s;
            if (rem_s == 32'd0) begin
              Valid   <= 1'b0;
              Busy    <= 1'b0;
              Done    <= 1'b1;
              state_r <= DONE;
            end else begin
              Addr <= search(rem_s, addr_inc_s);
            end
          end else begin
            Valid <= 1'b1;
          end
        end
        DONE: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          Valid   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          Valid   <= 1'b0;
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_encoder_32_5.sv
// Scoreboard bench for rr_encoder_32_5: expected addresses are queued by the stimulus,
// a monitor pops and compares on every accepted handshake.
module tb_rr_encoder_32_5;

  logic        Clk;
  logic        Rst;
  logic [31:0] ReqIn;
  logic        Load;
  logic        Ready;
  logic [4:0]  Addr;
  logic        Valid;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  rr_encoder_32_5 dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .ReqIn (ReqIn),
    .Load  (Load),
    .Ready (Ready),
    .Addr  (Addr),
    .Valid (Valid),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Load req with Ready held high and walk the batch; n = number of addresses expected.
  task automatic batch(input string name, input logic [31:0] req, input int n);
    ReqIn = req;
    Load  = 1'b1;
    Ready = 1'b1;
    tick();
    Load = 1'b0;
    chk({name, "_busy_first"}, {31'd0, Busy}, 32'd1);
    chk({name, "_valid_first"}, {31'd0, Valid}, 32'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      chk({name, "_valid_burst"}, {31'd0, Valid}, 32'd1);
      tick();
    end
    chk({name, "_done"}, {31'd0, Done}, 32'd1);
    chk({name, "_valid_end"}, {31'd0, Valid}, 32'd0);
    chk({name, "_busy_end"}, {31'd0, Busy}, 32'd0);
    tick();
    chk({name, "_done_clear"}, {31'd0, Done}, 32'd0);
    chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    Rst   = 1'b1;
    ReqIn = 32'd0;
    Load  = 1'b0;
    Ready = 1'b0;

    fork
      // Monitor: every accepted handshake must match the oldest expected address.
      forever begin
        @(negedge Clk);
        if (!Rst && Valid && Ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_addr: got %0d expected none at %0t", Addr, $time);
          end else begin
            chk("addr", {27'd0, Addr}, {27'd0, exp_q.pop_front()});
          end
        end
      end
    join_none

    // 1. Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      ReqIn = $urandom;
      Load  = 1'($urandom_range(0, 1));
      Ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_addr", {27'd0, Addr}, 32'd0);
    chk("rst_valid", {31'd0, Valid}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    Rst  = 1'b0;
    Load = 1'b0;
    exp_q.push_back(5'd0);
    batch("t1", 32'h0000_0001, 1);

    // 2. Burst with wrap from Ptr=0
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd31);
    batch("t2", 32'h8000_0005, 3);

    // 3. Round-robin across batches
    exp_q.push_back(5'd2);
    batch("t3a", 32'h0000_0004, 1);
    exp_q.push_back(5'd4);
    exp_q.push_back(5'd0);
    batch("t3b", 32'h0000_0011, 2);

    // 4. Backpressure with Load pulses ignored (Ptr=1, first offer is 5)
    ReqIn = 32'h0000_0060;
    Load  = 1'b1;
    Ready = 1'b0;
    tick();
    Load = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_addr", {27'd0, Addr}, 32'd5);
      chk("t4_hold_valid", {31'd0, Valid}, 32'd1);
      ReqIn = 32'hFFFF_0000;
      Load  = 1'b1;
      tick();
    end
    chk("t4_hold_addr_last", {27'd0, Addr}, 32'd5);
    Load = 1'b0;
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd6);
    Ready = 1'b1;
    tick();
    chk("t4_valid_second", {31'd0, Valid}, 32'd1);
    tick();
    chk("t4_done", {31'd0, Done}, 32'd1);
    chk("t4_valid_end", {31'd0, Valid}, 32'd0);
    tick();
    chk("t4_idle_valid", {31'd0, Valid}, 32'd0);
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // 5. Empty batch
    batch("t5", 32'h0000_0000, 0);

    // 6. Reset mid-batch (Ptr=7)
    exp_q.push_back(5'd7);
    exp_q.push_back(5'd8);
    exp_q.push_back(5'd9);
    ReqIn = 32'hFFFF_FFFF;
    Load  = 1'b1;
    Ready = 1'b1;
    tick();
    Load = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("t6_addr_before_rst", {27'd0, Addr}, 32'd10);
    Rst   = 1'b1;
    Ready = 1'b0;
    tick();
    Rst = 1'b0;
    chk("t6_valid", {31'd0, Valid}, 32'd0);
    chk("t6_busy", {31'd0, Busy}, 32'd0);
    chk("t6_done", {31'd0, Done}, 32'd0);
    tick();
    chk("t6_no_done", {31'd0, Done}, 32'd0);
    chk("t6_queue_empty", exp_q.size(), 32'd0);
    exp_q.push_back(5'd0);
    batch("t6b", 32'h0000_0001, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_encoder_32_5.md
# rr_encoder_32_5

Sequential 32-to-5 round-robin request encoder: the inverse of the register-file 5-to-32 write-address decoder. It captures a 32-bit multi-hot request vector and emits the index of each set bit as a 5-bit address, one per valid/ready handshake. Service order is round-robin from a persistent pointer. The block drives the address/write-enable path of the register file, or any consumer that needs a serialized index stream.

## Interface
- No parameters; widths fixed at 32 requests / 5-bit address.
- Clk  input  1  single clock; all state updates on rising edge
- Rst  input  1  reset, synchronous, active-high; sampled on rising edge of Clk, overrides all other inputs
- ReqIn  input  32  request vector; sampled only when Load accepted
- Load  input  1  capture ReqIn and start a batch; honored only in IDLE
- Ready  input  1  consumer accepts current Addr when Valid=1
- Addr  output  5  index of the request being offered (registered)
- Valid  output  1  Addr is valid (registered); usable directly as downstream WrEn
- Busy  output  1  batch in progress (FIRST or ISSUE state)
- Done  output  1  one-cycle pulse after the last request of a batch is accepted or an empty batch is processed

## Operation
- State: FSM {IDLE, FIRST, ISSUE, DONE}; Pending[31:0]; Ptr[4:0]; registered Addr and Valid.
- search(P, S): first index i in the order S, S+1, …, 31, 0, …, S-1 with P[i]=1. Indices are 5-bit and wrap mod 32.
- IDLE: Valid=0, Busy=0.
  - Load=1: Pending<=ReqIn, go to FIRST.
  - Ready is ignored.
- FIRST (Busy=1):
  - Pending==0: go to DONE; Valid stays 0.
  - Otherwise: Addr<=search(Pending, Ptr), Valid<=1, go to ISSUE.
- ISSUE (Busy=1, Valid=1):
  - Ready=0: hold Addr, Pending, Ptr.
  - Ready=1: Rem = Pending with bit Addr cleared; Pending<=Rem; Ptr<=Addr+1 (31 wraps to 0).
    - Rem==0: Valid<=0, go to DONE.
    - Otherwise: Addr<=search(Rem, Addr+1), stay in ISSUE.
- DONE: Done=1, Busy=0, Valid=0; go to IDLE next cycle.
- Load outside IDLE is ignored; ReqIn is not re-sampled.
- Ptr is not modified by Load. Round-robin fairness carries across batches.
- Ptr changes only on reset or on an accepted handshake.
- Ready while Valid=0 has no effect.

## Timing
- Reset (Rst=1 at an edge), in any state, takes effect at that edge:
  - state=IDLE, Pending=0, Ptr=0;
  - Addr=0, Valid=0, Busy=0, Done=0.
- Reset mid-batch aborts the batch with no Done pulse.
- Rst and Load asserted together: Rst wins.
- Load accepted at edge k: FIRST in cycle k+1, Valid=1 from cycle k+2.
  - Load→first Valid latency is 2 cycles.
- With Ready held high: one accepted address per cycle, no bubbles.
  - N requests occupy N consecutive Valid cycles.
- Last handshake at edge e: Done=1 in cycle e+1, IDLE in e+2. Next Load is honored at edge e+2 at the earliest.
- Empty batch: Load at edge k gives Busy=1 in cycle k+1, Done=1 in cycle k+2, IDLE at k+3.
- Addr stays stable for the whole time Valid=1 and Ready=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
1. **Reset:** hold Rst=1 two cycles with random ReqIn/Load/Ready → Addr=0, Valid=0, Busy=0, Done=0. Then Load with ReqIn=0x1 → Addr=0 offered, proving Ptr=0.
2. **Burst with wrap:** Ptr=0, Load ReqIn=0x8000_0005, Ready=1.
   - Valid high three consecutive cycles from k+2 with Addr=0, 2, 31.
   - Done one cycle later; Ptr ends at 0.
3. **Round-robin across batches:** batch ReqIn=0x0000_0004 (Addr=2, Ptr→3), then batch ReqIn=0x0000_0011 → Addr=4, then Addr=0.
4. **Backpressure:** in ISSUE with Addr=5, hold Ready=0 for 3 cycles while pulsing Load with other ReqIn.
   - Addr stays 5 and Valid stays 1; Pending is unchanged; Load is ignored.
   - On Ready=1 the batch continues with the original requests only.
5. **Empty batch:** Load ReqIn=0 → Valid never asserted; Busy=1 in cycle k+1; Done=1 in cycle k+2; IDLE after.
6. **Reset mid-batch:** Load ReqIn=0xFFFF_FFFF, accept 3 addresses, assert Rst.
   - Next cycle: Valid=0, Busy=0, no Done pulse.
   - A following Load of 0x1 yields Addr=0.
